// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Shared types and constants for the UART transmit scheduler.
//   UartTxSource_t : which byte source owns the transmitter
//   UartTxState_t  : scheduler FSM states
//   TX_ARM_TIMEOUT : cycles to wait in ARM for txBusy before giving up
// -----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

   typedef enum logic {
      TX_SRC_KBD = 1'b0,
      TX_SRC_RSP = 1'b1
   } UartTxSource_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_ARM   = 2'd2,
      TX_BUSY  = 2'd3
   } UartTxState_t;

   localparam int unsigned TX_ARM_TIMEOUT = 4;

   // Value of the ARM counter on the final ARM cycle before the timeout fires.
   localparam logic [2:0] TX_ARM_LAST = 3'(TX_ARM_TIMEOUT - 1);

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// -----------------------------------------------------------------------------
// tx_byte_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible
// combinationally on `head` whenever `empty` is low.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request; accepted when not full, or when a pop
//                     happens in the same cycle
//   pop             : remove head entry (ignored when empty)
//   head            : current head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries
// -----------------------------------------------------------------------------
module tx_byte_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_FULL = {1'b1, {PTR_W{1'b0}}};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (count_r == CNT_FULL);
   assign empty_s   = (count_r == {(PTR_W+1){1'b0}});
   assign pop_ok_s  = pop && !empty_s;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign push_ok_s = push && (!full_s || pop_ok_s);

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_s;
   assign empty = empty_s;
   assign count = count_r;

   // Storage array: no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between keyboard bytes and VT100 reply strings.
// Both sources are buffered; messages are interleaved round-robin, and a reply
// string is never split by keyboard bytes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   kbdValid, kbdData : keyboard byte strobe (no backpressure)
//   rspValid, rspData, rspLast, rspReady : reply byte valid/ready stream
//   txStart, txData   : transmitter start pulse and held byte
//   txBusy            : transmitter busy
//   kbdOverflow       : sticky flag, a keyboard byte was dropped
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned KBD_DEPTH = 16,
   parameter int unsigned RSP_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbdValid,
   input  logic [7:0] kbdData,
   input  logic       rspValid,
   input  logic [7:0] rspData,
   input  logic       rspLast,
   output logic       rspReady,
   output logic       txStart,
   output logic [7:0] txData,
   input  logic       txBusy,
   output logic       kbdOverflow
);

   UartTxState_t  state_r;
   UartTxSource_t last_grant_r;
   logic          lock_rsp_r;
   logic          tx_start_r;
   logic [7:0]    tx_data_r;
   logic [2:0]    arm_cnt_r;
   logic          kbd_overflow_r;

   logic [7:0]    kbd_head_s;
   logic          kbd_full_s;
   logic          kbd_empty_s;
   logic [$clog2(KBD_DEPTH):0] kbd_count_s;
   logic [8:0]    rsp_head_s;
   logic          rsp_full_s;
   logic          rsp_empty_s;
   logic [$clog2(RSP_DEPTH):0] rsp_count_s;
   logic          grant_kbd_s;
   logic          grant_rsp_s;
   logic          kbd_push_ok_s;
   logic          rsp_ready_s;
   logic          unused_count_s;

   assign unused_count_s = ^{kbd_count_s, rsp_count_s};

   tx_byte_fifo #(
      .WIDTH (8),
      .DEPTH (KBD_DEPTH)
   ) u_kbd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (kbdValid),
      .push_data (kbdData),
      .pop       (grant_kbd_s),
      .head      (kbd_head_s),
      .full      (kbd_full_s),
      .empty     (kbd_empty_s),
      .count     (kbd_count_s)
   );

   tx_byte_fifo #(
      .WIDTH (9),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rspValid && rsp_ready_s),
      .push_data ({rspLast, rspData}),
      .pop       (grant_rsp_s),
      .head      (rsp_head_s),
      .full      (rsp_full_s),
      .empty     (rsp_empty_s),
      .count     (rsp_count_s)
   );

   assign rsp_ready_s   = !rsp_full_s || grant_rsp_s;
   assign kbd_push_ok_s = !kbd_full_s || grant_kbd_s;

   assign rspReady    = rsp_ready_s;
   assign txStart     = tx_start_r;
   assign txData      = tx_data_r;
   assign kbdOverflow = kbd_overflow_r;

   // Message-level arbitration, only in IDLE with the transmitter free.
   always_comb begin
      grant_kbd_s = 1'b0;
      grant_rsp_s = 1'b0;
      if ((state_r == TX_IDLE) && !txBusy) begin
         if (lock_rsp_r) begin
            // Inside a reply string: wait for its next byte, never the keyboard.
            grant_rsp_s = !rsp_empty_s;
         end else if (!kbd_empty_s && !rsp_empty_s) begin
            if (last_grant_r == TX_SRC_KBD) begin
               grant_rsp_s = 1'b1;
            end else begin
               grant_kbd_s = 1'b1;
            end
         end else begin
            grant_kbd_s = !kbd_empty_s;
            grant_rsp_s = !rsp_empty_s;
         end
      end else begin
         grant_kbd_s = 1'b0;
         grant_rsp_s = 1'b0;
      end
   end

   // Sticky keyboard overflow: a strobe the FIFO could not take.
   always_ff @(posedge clk) begin
      if (rst) begin
         kbd_overflow_r <= 1'b0;
      end else if (kbdValid && !kbd_push_ok_s) begin
         kbd_overflow_r <= 1'b1;
      end else begin
         kbd_overflow_r <= kbd_overflow_r;
      end
   end

   // Scheduler FSM: grant/pop, start pulse, wait for busy, wait for done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= TX_IDLE;
         last_grant_r <= TX_SRC_KBD;
         lock_rsp_r   <= 1'b0;
         tx_start_r   <= 1'b0;
         tx_data_r    <= 8'h00;
         arm_cnt_r    <= 3'd0;
      end else begin
         case (state_r)
            TX_IDLE: begin
               if (grant_kbd_s) begin
                  tx_data_r    <= kbd_head_s;
                  last_grant_r <= TX_SRC_KBD;
                  tx_start_r   <= 1'b1;
                  state_r      <= TX_START;
               end else if (grant_rsp_s) begin
                  tx_data_r  <= rsp_head_s[7:0];
                  // Only the first byte of a string counts as a new message.
                  if (!lock_rsp_r) begin
                     last_grant_r <= TX_SRC_RSP;
                  end
                  lock_rsp_r <= !rsp_head_s[8];
                  tx_start_r <= 1'b1;
                  state_r    <= TX_START;
               end else begin
                  tx_start_r <= 1'b0;
               end
            end
            TX_START: begin
               tx_start_r <= 1'b0;
               arm_cnt_r  <= 3'd0;
               state_r    <= TX_ARM;
            end
            TX_ARM: begin
               if (txBusy) begin
                  state_r <= TX_BUSY;
               end else if (arm_cnt_r == TX_ARM_LAST) begin
                  // Busy never showed up; don't deadlock on a missed pulse.
                  state_r <= TX_IDLE;
               end else begin
                  arm_cnt_r <= arm_cnt_r + 3'd1;
               end
            end
            TX_BUSY: begin
               if (!txBusy) begin
                  state_r <= TX_IDLE;
               end
            end
            default: begin
               tx_start_r <= 1'b0;
               state_r    <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kbdValid = 1'b0;
   logic [7:0] kbdData = 8'h00;
   logic       rspValid = 1'b0;
   logic [7:0] rspData = 8'h00;
   logic       rspLast = 1'b0;
   logic       rspReady;
   logic       txStart;
   logic [7:0] txData;
   logic       txBusy = 1'b0;
   logic       kbdOverflow;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [7:0] exp_q [$];

   // transmitter model controls
   int busy_len = 20;
   bit hold_busy = 1'b0;
   int busy_cnt = 0;
   int start_cnt = 0;
   int last_start_cyc = 0;
   int prev_start_cyc = 0;

   uart_tx_scheduler #(
      .KBD_DEPTH (16),
      .RSP_DEPTH (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .kbdValid    (kbdValid),
      .kbdData     (kbdData),
      .rspValid    (rspValid),
      .rspData     (rspData),
      .rspLast     (rspLast),
      .rspReady    (rspReady),
      .txStart     (txStart),
      .txData      (txData),
      .txBusy      (txBusy),
      .kbdOverflow (kbdOverflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor + transmitter model: scoreboard pop on each start pulse.
   always @(negedge clk) begin
      logic [7:0] e;
      if (txStart === 1'b1) begin
         prev_start_cyc = last_start_cyc;
         last_start_cyc = cyc;
         start_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_start: got txData %0h expected no start", txData);
         end else begin
            e = exp_q.pop_front();
            check("txData", {24'h0, txData}, {24'h0, e});
         end
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      txBusy = hold_busy || (busy_cnt > 0);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic kbd_byte(input logic [7:0] d);
      kbdValid = 1'b1;
      kbdData  = d;
      step();
      kbdValid = 1'b0;
   endtask

   task automatic rsp_byte(input logic [7:0] d, input logic last);
      int b = 0;
      rspValid = 1'b1;
      rspData  = d;
      rspLast  = last;
      while (!rspReady && b < 200) begin
         step();
         b++;
      end
      if (b >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL rsp_ready_timeout: got rspReady 0 expected 1");
      end
      step();
      rspValid = 1'b0;
      rspLast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int b = 0;
      while (exp_q.size() > 0 && b < 3000) begin
         step();
         b++;
      end
      check(name, exp_q.size(), 32'd0);
      repeat (busy_len + 12) step();
   endtask

   logic [7:0] rsp_str [6];
   int w;
   int s0;

   initial begin
      rsp_str[0] = 8'h1B; rsp_str[1] = 8'h5B; rsp_str[2] = 8'h32;
      rsp_str[3] = 8'h3B; rsp_str[4] = 8'h35; rsp_str[5] = 8'h52;

      repeat (3) step();
      rst = 1'b0;
      check("reset_txStart", {31'h0, txStart}, 32'd0);
      check("reset_txData", {24'h0, txData}, 32'h00);
      check("reset_kbdOverflow", {31'h0, kbdOverflow}, 32'd0);
      check("reset_rspReady", {31'h0, rspReady}, 32'd1);
      step();

      // single key: start two edges after the write, only one pulse
      busy_len = 20;
      s0 = start_cnt;
      exp_q.push_back(8'h41);
      kbdValid = 1'b1;
      kbdData  = 8'h41;
      step();
      w = cyc;
      kbdValid = 1'b0;
      wait_drain("single_drain");
      check("single_latency", last_start_cyc - w, 32'd1);
      check("single_count", start_cnt - s0, 32'd1);

      // reply lock: keyboard bytes wait for the whole string
      foreach (rsp_str[i]) exp_q.push_back(rsp_str[i]);
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      for (int i = 0; i < 6; i++) begin
         rspValid = 1'b1;
         rspData  = rsp_str[i];
         rspLast  = (i == 5);
         kbdValid = (i == 2) || (i == 4);
         kbdData  = (i == 2) ? 8'h61 : 8'h62;
         check("lock_rspReady", {31'h0, rspReady}, 32'd1);
         step();
         kbdValid = 1'b0;
      end
      rspValid = 1'b0;
      rspLast  = 1'b0;
      wait_drain("lock_drain");

      // round-robin from reset (lastGrant = KBD, so reply goes first)
      do_reset();
      hold_busy = 1'b1;
      step();
      step();
      kbd_byte(8'h61);
      kbd_byte(8'h62);
      rsp_byte(8'h30, 1'b1);
      rsp_byte(8'h31, 1'b1);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h62);
      hold_busy = 1'b0;
      wait_drain("rr_drain");

      // overflow: 17 strobes while busy, 17th dropped
      do_reset();
      hold_busy = 1'b1;
      step();
      step();
      for (int i = 0; i < 17; i++) begin
         kbdValid = 1'b1;
         kbdData  = 8'h80 + 8'(i);
         step();
      end
      kbdValid = 1'b0;
      check("ovf_set", {31'h0, kbdOverflow}, 32'd1);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
      hold_busy = 1'b0;
      wait_drain("ovf_drain");
      check("ovf_sticky", {31'h0, kbdOverflow}, 32'd1);

      // full FIFO with a same-cycle pop accepts the write
      do_reset();
      check("fullpop_ovf_cleared", {31'h0, kbdOverflow}, 32'd0);
      hold_busy = 1'b1;
      step();
      step();
      for (int i = 0; i < 16; i++) begin
         kbdValid = 1'b1;
         kbdData  = 8'h90 + 8'(i);
         step();
      end
      kbdValid = 1'b0;
      check("full_no_ovf", {31'h0, kbdOverflow}, 32'd0);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h90 + 8'(i));
      exp_q.push_back(8'hA0);
      hold_busy = 1'b0;
      step();
      kbdValid = 1'b1;
      kbdData  = 8'hA0;
      step();
      kbdValid = 1'b0;
      check("fullpop_no_ovf", {31'h0, kbdOverflow}, 32'd0);
      wait_drain("fullpop_drain");

      // busy guard: txBusy never rises, ARM times out after 4 cycles
      do_reset();
      busy_len = 0;
      exp_q.push_back(8'h71);
      exp_q.push_back(8'h72);
      kbd_byte(8'h71);
      kbd_byte(8'h72);
      wait_drain("guard_drain");
      check("guard_gap", last_start_cyc - prev_start_cyc, 32'd6);

      // reset while BUSY with both FIFOs holding data
      do_reset();
      busy_len = 20;
      s0 = start_cnt;
      exp_q.push_back(8'h55);
      kbd_byte(8'h55);
      w = 0;
      while (start_cnt == s0 && w < 50) begin
         step();
         w++;
      end
      check("rstbusy_first_start", start_cnt - s0, 32'd1);
      hold_busy = 1'b1;
      step();
      for (int i = 0; i < 17; i++) begin
         kbdValid = 1'b1;
         kbdData  = 8'hC0 + 8'(i);
         step();
      end
      kbdValid = 1'b0;
      rsp_byte(8'h40, 1'b1);
      check("rstbusy_ovf_before", {31'h0, kbdOverflow}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstbusy_txStart", {31'h0, txStart}, 32'd0);
      check("rstbusy_rspReady", {31'h0, rspReady}, 32'd1);
      check("rstbusy_kbdOverflow", {31'h0, kbdOverflow}, 32'd0);
      check("rstbusy_kbd_empty", {31'h0, dut.u_kbd_fifo.empty}, 32'd1);
      check("rstbusy_rsp_empty", {31'h0, dut.u_rsp_fifo.empty}, 32'd1);
      s0 = start_cnt;
      hold_busy = 1'b0;
      repeat (60) step();
      check("rstbusy_no_start", start_cnt - s0, 32'd0);
      check("final_queue", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single UART transmitter between two byte sources: keyboard ASCII bytes (one-cycle strobes, no backpressure) and VT100 parser reply strings (for example cursor-position and device-status reports, sent with valid/ready). It buffers both sources and interleaves them at message granularity using round-robin. A reply string is never split by keyboard bytes. It drives the transmitter's start/busy handshake and sits between the keyboard/parser logic and the UART transmitter.

## Interface
Parameters:
- `KBD_DEPTH`, 16: keyboard FIFO entries; power of two, at least 2.
- `RSP_DEPTH`, 16: reply FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  transmitter clock domain. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `kbdValid`  in  1  one-cycle strobe; `kbdData` is valid this cycle.
- `kbdData`  in  8  keyboard ASCII byte.
- `rspValid`  in  1  reply byte offered.
- `rspData`  in  8  reply byte.
- `rspLast`  in  1  marks the final byte of a reply string.
- `rspReady`  out  1  reply FIFO can accept a byte.
- `txStart`  out  1  one-cycle start pulse to the transmitter.
- `txData`  out  8  byte to send; held stable from `txStart` until the byte completes.
- `txBusy`  in  1  transmitter busy.
- `kbdOverflow`  out  1  sticky; set when a keyboard byte is dropped.

## Operation
- **Keyboard FIFO**
  - Each entry is 8 bits.
  - A write occurs on `kbdValid` when not full, or when a pop happens in the same cycle.
  - Otherwise the byte is discarded and `kbdOverflow` is set until `rst`.
- **Reply FIFO**
  - Each entry is 9 bits: {last, data}.
  - Transfer occurs when `rspValid && rspReady`.
  - `rspReady = !rspFull || rspPop`. A full FIFO popping in the same cycle still accepts.
- **Arbitration**
  - Performed in IDLE only, and only when `txBusy == 0`.
  - A keyboard message is 1 byte. A reply message runs up to and including the entry with last = 1.
  - If `lockRsp` is set, grant the reply FIFO, or wait if it is empty. The keyboard is never served while locked.
  - Otherwise, if exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the source other than `lastGrant`.
  - `lastGrant` updates on the first byte of each message. `lockRsp` is set on a reply pop with last = 0 and cleared on a pop with last = 1.
- **FSM states**
  - IDLE: on a grant, pop the chosen FIFO, register `txData`, go to START.
  - START: `txStart = 1` for exactly this cycle; go to ARM.
  - ARM: wait for `txBusy = 1`, then go to BUSY. If `txBusy` stays low for 4 cycles in ARM, go to IDLE (guard against a missed busy).
  - BUSY: wait for `txBusy = 0`, then go to IDLE.
- **Reset mid-operation**
  - Both FIFOs are emptied; FSM goes to IDLE; `lockRsp` and `lastGrant` (KBD) are cleared; `kbdOverflow` goes to 0.
  - A byte already inside the transmitter finishes independently. IDLE still waits for `txBusy = 0` before the next grant.
- **Pointers** are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Timing
- **Reset values:** `txStart` = 0, `txData` = 8'h00, `kbdOverflow` = 0, `rspReady` = 1.
- **Latency:** write at cycle N into an empty FIFO with the scheduler idle and `txBusy` low gives a grant at N+1 and `txStart` high at N+2.
- **Back-to-back bytes:** minimum gap between `txStart` pulses is one transmitter busy period + 3 cycles.
- `txData` is registered and changes only in IDLE on a grant.

## Structure
- **Shared package:** `UartTxSource_t` enum {TX_SRC_KBD, TX_SRC_RSP}, `UartTxState_t` enum {TX_IDLE, TX_START, TX_ARM, TX_BUSY}, constant `TX_ARM_TIMEOUT = 4`.
- **Sub-module:** `tx_byte_fifo`, a parameterized width/depth synchronous FIFO with first-word fall-through (head is visible combinationally), and full, empty and count outputs. It is instantiated twice: width 8 for the keyboard, width 9 for replies.
- The scheduler FSM and arbitration live in the top.

## Test plan
- **Single key:** `kbdData = 8'h41` with the transmitter model busy for 20 cycles → `txStart` at N+2 with `txData = 8'h41`; no further pulse.
- **Reply lock:** reply string 1B 5B 32 3B 35 52 (last on 52), pushed contiguously, then keyboard 61 and 62 pushed during the string → transmitted order 1B 5B 32 3B 35 52 61 62. No keyboard byte appears inside the string.
- **Round-robin:** both FIFOs pre-loaded (keyboard 61 62; replies 30(last), 31(last)), `lastGrant` = KBD after reset → order 30 61 31 62.
- **Overflow:** 17 keyboard strobes while `txBusy` is held high → 16 bytes stored, `kbdOverflow` = 1, 17th byte never sent. A simultaneous full-and-pop write is accepted without setting `kbdOverflow`.
- **Busy guard and reset:**
  - `txBusy` never asserts → 4 cycles in ARM, then the next byte launches.
  - `rst` asserted in BUSY → next cycle both FIFOs are empty, `txStart` = 0, `rspReady` = 1, `kbdOverflow` = 0.
